score_display_scan: RTL and testbench
=====================================

// Module: score_display_scan
// PURPOSE
//  Converts a binary score to BCD with a sequential double-dabble engine.
//  Time-multiplexes the BCD digits onto one 4-bit hex bus that drives the seven_seg decoder.
//  Drives active-low digit enables in step with the hex bus.
//  Sits between the game controller (score source) and seven_seg (segment decode).
// PARAMETERS
//  SCORE_W     8      width of binary score input (>=1)
//  NUM_DIGITS  4      BCD digits displayed (1..8)
//  SCAN_DIV    50000  clk cycles each digit is held before advancing (>=2)
// PORTS
//  clk          in   1               system clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  score        in   SCORE_W         binary value to display, sampled when score_valid=1
//  score_valid  in   1               one-cycle load strobe
//  blank        in   1               1 = all digit enables inactive (display dark)
//  hex          out  4               BCD digit of current scan slot, to seven_seg
//  digit_en_n   out  NUM_DIGITS      active-low one-hot enable; bit i = digit i (0 = units)
//  busy         out  1               conversion in progress
//  overflow     out  1               last converted score did not fit NUM_DIGITS
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - hex=0, digit_en_n=all 1, busy=0, overflow=0.
//   - Display register=0, pending flag=0, scan index=0, prescaler=0, FSM=IDLE.
//  Converter FSM (IDLE, CONV, DONE):
//   - IDLE: score_valid=1 (or pending=1) -> load shift reg with score, clear BCD accumulator,
//     iteration count=0, go CONV; busy=1 from the next cycle.
//   - CONV: one iteration per clk: add 3 to every BCD nibble >=5, then shift left 1
//     (MSB of score enters units nibble).
//   - CONV: a 1 shifted out of the top nibble sets an internal ovf bit.
//   - CONV: after SCORE_W iterations -> DONE.
//   - DONE (1 cycle): copy accumulator to display register. If ovf, write all digits 4'd9 instead.
//     overflow<=ovf; busy<=0; -> IDLE.
//   - Latency: strobe at cycle T -> display register updated at edge T+SCORE_W+2; busy high T+1..T+SCORE_W+1.
//   - score_valid while busy: value captured into pending register, pending=1; most recent
//     strobe wins. Conversion of it starts from IDLE the cycle after DONE.
//   - Display register never shows partial results.
//  Scan:
//   - Prescaler counts 0..SCAN_DIV-1 continuously, free-running, independent of FSM.
//   - On wrap, scan index advances, NUM_DIGITS-1 -> 0.
//   - hex and digit_en_n are registered and update together on the cycle after index changes.
//   - hex = display digit[index].
//   - digit_en_n[index]=0 unless blank=1, or leading-zero suppression applies.
//   - Leading-zero suppression: digit i>0 is dark when it and all higher digits are 0.
//     Units digit is never suppressed.
//   - Non-selected enables are always 1; never more than one enable low.
//  Overflow detection relies on carry out of top nibble; equivalent to score >= 10^NUM_DIGITS.
//  blank affects only digit_en_n; conversion and scanning continue.
// TESTING (SCAN_DIV=4 unless noted)
//  1. Reset: hold rst_n=0 mid-scan -> hex=0, digit_en_n=4'b1111, busy=0 immediately (async).
//     After release, digit 0 enabled with hex=0 after first registered update.
//  2. score=123 strobe, SCORE_W=8 -> busy for 9 cycles.
//     Scan shows digit0=3, digit1=2, digit2=1; digit3 dark (suppressed); overflow=0.
//  3. NUM_DIGITS=2, score=255 -> overflow=1; both digits show 9; score=42 next -> overflow=0, shows 4,2.
//  4. Strobe 7, then strobe 50 two cycles later (busy) -> display passes 7 then settles at 50.
//     A third strobe 60 during 50's conversion -> final display 60.
//  5. score=0 -> only digit_en_n[0]=0 at its slot, hex=0; blank=1 -> digit_en_n=all 1 every slot.
//  6. Assert rst_n=0 during CONV with score=99 -> display register stays 0 and busy=0 after release.
//     No stale result appears; pending flag cleared.

Source files
------------

// File: rtl/score_display_scan.sv
// Binary score -> BCD via a sequential double-dabble engine, then time-multiplexed
// onto a single hex bus with active-low digit enables and leading-zero suppression.
module score_display_scan #(
  parameter int SCORE_W    = 8,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  score_valid,
  input  logic                  blank,
  output logic [3:0]            hex,
  output logic [NUM_DIGITS-1:0] digit_en_n,
  output logic                  busy,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int ITER_W  = $clog2(SCORE_W + 1);
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SCORE_W-1:0] r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [ITER_W-1:0]  r_iter;
  logic               r_ovf;
  logic               r_pending;
  logic [SCORE_W-1:0] r_pend_score;
  logic [BCD_W-1:0]   r_disp;
  logic               r_overflow;
  logic [PRESC_W-1:0] r_presc;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_hex;
  logic [NUM_DIGITS-1:0] r_en_n;

  logic               w_load;
  logic [SCORE_W-1:0] w_load_value;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_step;
  logic               w_carry;
  logic [3:0]         w_digit;
  logic [NUM_DIGITS-1:0] w_upper_zero;
  logic [NUM_DIGITS-1:0] w_en_n;
  logic               w_zero_run;

  // Load protocol: score_valid is a one-cycle strobe with no ready/back-pressure.
  // A strobe while the engine is busy lands in a depth-1 pending slot (newest wins)
  // and is converted from IDLE; busy only reports that a conversion is in flight.

  // Double-dabble step: adjust every nibble >=5 by +3, then shift the score MSB in.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      else                         w_adj[4*i +: 4] = r_bcd[4*i +: 4];
    end
    w_bcd_step = {w_adj[BCD_W-2:0], r_shift[SCORE_W-1]};
    w_carry    = w_adj[BCD_W-1];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_value = score_valid ? score : r_pend_score;
    case (r_state)
      S_IDLE: begin
        if (score_valid || r_pending) begin
          w_load      = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (r_iter == ITER_W'(SCORE_W - 1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bcd        <= '0;
      r_iter       <= '0;
      r_ovf        <= 1'b0;
      r_pending    <= 1'b0;
      r_pend_score <= '0;
      r_disp       <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_load) begin
        r_shift <= w_load_value;
        r_bcd   <= '0;
        r_iter  <= '0;
        r_ovf   <= 1'b0;
      end else if (r_state == S_CONV) begin
        r_shift <= r_shift << 1;
        r_bcd   <= w_bcd_step;
        r_iter  <= r_iter + ITER_W'(1);
        if (w_carry) r_ovf <= 1'b1;
      end

      // Only the finished accumulator is ever copied, so partial results stay hidden.
      if (r_state == S_DONE) begin
        r_disp     <= r_ovf ? {NUM_DIGITS{4'd9}} : r_bcd;
        r_overflow <= r_ovf;
      end

      if ((r_state != S_IDLE) && score_valid) begin
        r_pending    <= 1'b1;
        r_pend_score <= score;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Free-running scan prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRESC_W'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      if (r_idx == IDX_W'(NUM_DIGITS - 1)) r_idx <= '0;
      else                                 r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  always_comb begin
    w_digit      = 4'd0;
    w_upper_zero = '0;
    w_en_n       = '1;
    w_zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run      = w_zero_run & (r_disp[4*i +: 4] == 4'd0);
      w_upper_zero[i] = w_zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_digit = r_disp[4*i +: 4];
        // Units digit is never suppressed so a zero score still lights one digit.
        if (!blank && !((i > 0) && w_upper_zero[i])) w_en_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex  <= 4'd0;
      r_en_n <= '1;
    end else begin
      r_hex  <= w_digit;
      r_en_n <= w_en_n;
    end
  end

  assign hex        = r_hex;
  assign digit_en_n = r_en_n;
  assign busy       = (r_state != S_IDLE);
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_score_display_scan.sv
// Bench for score_display_scan: a 4-digit and a 2-digit instance, a completion
// scoreboard keyed on busy falling, and scan observation over whole rotations.
module tb_score_display_scan;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       blank;
  logic [7:0] score1, score2;
  logic       valid1, valid2;
  logic [3:0] hex1, hex2;
  logic [3:0] en1;
  logic [1:0] en2;
  logic       busy1, busy2, ovf1, ovf2;
  logic [1:0] st1, st2;

  score_display_scan #(.SCORE_W(8), .NUM_DIGITS(4), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .score(score1), .score_valid(valid1), .blank(blank),
    .hex(hex1), .digit_en_n(en1), .busy(busy1), .overflow(ovf1), .dbg_state(st1)
  );

  score_display_scan #(.SCORE_W(8), .NUM_DIGITS(2), .SCAN_DIV(SCAN_DIV)) dut2 (
    .clk(clk), .rst_n(rst_n), .score(score2), .score_valid(valid2), .blank(blank),
    .hex(hex2), .digit_en_n(en2), .busy(busy2), .overflow(ovf2), .dbg_state(st2)
  );

  int checks = 0;
  int errors = 0;

  // {overflow, digit3..digit0}; 4'hF marks a digit that must stay dark
  logic [16:0] exp_q[$];
  logic [16:0] exp_q2[$];
  logic        busy1_prev = 1'b0;
  logic        busy2_prev = 1'b0;

  function automatic logic [16:0] exp_word(input int value, input int nd);
    logic [15:0] w;
    int p, v, top;
    int d [8];
    w = 16'hFFFF;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    if (value >= p) begin
      for (int i = 0; i < nd; i++) w[4*i +: 4] = 4'd9;
      return {1'b1, w};
    end
    v = value;
    top = 0;
    for (int i = 0; i < nd; i++) begin
      d[i] = v % 10;
      v = v / 10;
      if (d[i] != 0) top = i;
    end
    for (int i = 0; i <= top; i++) w[4*i +: 4] = 4'(d[i]);
    return {1'b0, w};
  endfunction

  // Scoreboard: each busy falling edge is one completed conversion.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      busy1_prev = 1'b0;
      busy2_prev = 1'b0;
    end else begin
      if (busy1_prev && !busy1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL completion_unexpected dut: got a completion (overflow=%0b), required none", ovf1);
        end else begin
          e = exp_q.pop_front();
          if (ovf1 !== e[16]) begin
            errors++;
            $display("FAIL completion_overflow dut: got %0b, required %0b", ovf1, e[16]);
          end
        end
      end
      if (busy2_prev && !busy2) begin
        checks++;
        if (exp_q2.size() == 0) begin
          errors++;
          $display("FAIL completion_unexpected dut2: got a completion (overflow=%0b), required none", ovf2);
        end else begin
          e = exp_q2.pop_front();
          if (ovf2 !== e[16]) begin
            errors++;
            $display("FAIL completion_overflow dut2: got %0b, required %0b", ovf2, e[16]);
          end
        end
      end
      busy1_prev = busy1;
      busy2_prev = busy2;
    end
  end

  task automatic strobe1(input logic [7:0] v);
    score1 = v;
    valid1 = 1'b1;
    exp_q.push_back(exp_word(int'(v), 4));
    @(negedge clk);
    valid1 = 1'b0;
  endtask

  task automatic strobe2(input logic [7:0] v);
    score2 = v;
    valid2 = 1'b1;
    exp_q2.push_back(exp_word(int'(v), 2));
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  task automatic wait_drain(input bit sel);
    int n;
    for (int k = 0; k < 200; k++) begin
      n = sel ? exp_q2.size() : exp_q.size();
      if (n == 0) break;
      @(negedge clk);
    end
    n = sel ? exp_q2.size() : exp_q.size();
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL drain_timeout sel=%0d: got %0d outstanding, required 0", sel, n);
    end
    @(negedge clk);
  endtask

  // Observe two full rotations; per digit record the shown value, 4'hE on inconsistency.
  task automatic collect(input bit sel, output logic [15:0] word, output int multi);
    logic [3:0] en, h, seen;
    int lows, pos;
    word = 16'hFFFF;
    seen = 4'b0000;
    multi = 0;
    repeat (8 * SCAN_DIV) begin
      @(negedge clk);
      en = sel ? {2'b11, en2} : en1;
      h  = sel ? hex2 : hex1;
      lows = 0;
      pos = 0;
      for (int i = 0; i < 4; i++) if (!en[i]) begin lows++; pos = i; end
      if (lows > 1) multi++;
      else if (lows == 1) begin
        if (!seen[pos]) begin
          word[4*pos +: 4] = h;
          seen[pos] = 1'b1;
        end else if (word[4*pos +: 4] !== h) begin
          word[4*pos +: 4] = 4'hE;
        end
      end
    end
  endtask

  task automatic test_reset;
    bit found;
    rst_n = 1'b0; blank = 1'b0;
    valid1 = 1'b0; valid2 = 1'b0; score1 = '0; score2 = '0;
    #12;
    checks++;
    if (hex1 !== 4'd0 || en1 !== 4'b1111 || busy1 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got hex=%0d en=%b busy=%b ovf=%b, required 0 1111 0 0", hex1, en1, busy1, ovf1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (en1 !== 4'b1110 || hex1 !== 4'd0 || en2 !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_update: got en=%b hex=%0d en2=%b, required 1110 0 10", en1, hex1, en2);
    end
    strobe1(8'd5);
    wait_drain(1'b0);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (en1 === 4'b1110 && hex1 === 4'd5) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_prescan: got en=%b hex=%0d, required units slot showing 5", en1, hex1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hex1 !== 4'd0 || en1 !== 4'b1111 || busy1 !== 1'b0 || st1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: got hex=%0d en=%b busy=%b state=%0d, required 0 1111 0 0", hex1, en1, busy1, st1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_convert;
    int cnt;
    logic [16:0] e;
    logic [15:0] w;
    int multi;
    e = exp_word(123, 4);
    strobe1(8'd123);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy1) cnt++;
      else if (cnt > 0) break;
      @(negedge clk);
    end
    checks++;
    if (cnt != 9) begin
      errors++;
      $display("FAIL convert_busy_cycles: got %0d, required 9", cnt);
    end
    wait_drain(1'b0);
    collect(1'b0, w, multi);
    checks++;
    if (w !== e[15:0] || multi != 0) begin
      errors++;
      $display("FAIL convert_123_digits: got %h (multi=%0d), required %h (multi=0)", w, multi, e[15:0]);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] w;
    int multi;
    strobe2(8'd255);
    wait_drain(1'b1);
    collect(1'b1, w, multi);
    checks++;
    if (w !== 16'hFF99 || ovf2 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_255: got %h ovf=%b, required ff99 ovf=1", w, ovf2);
    end
    strobe2(8'd42);
    wait_drain(1'b1);
    collect(1'b1, w, multi);
    checks++;
    if (w !== 16'hFF42 || ovf2 !== 1'b0 || multi != 0) begin
      errors++;
      $display("FAIL overflow_recover_42: got %h ovf=%b multi=%0d, required ff42 ovf=0 multi=0", w, ovf2, multi);
    end
  endtask

  task automatic test_back_to_back;
    logic [16:0] e;
    logic [15:0] w;
    int multi;
    e = exp_word(60, 4);
    strobe1(8'd7);
    @(negedge clk);
    strobe1(8'd50);
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() <= 1) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pending_started: got busy=%b, required 1", busy1);
    end
    strobe1(8'd60);
    wait_drain(1'b0);
    collect(1'b0, w, multi);
    checks++;
    if (w !== e[15:0] || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final_60: got %h busy=%b, required %h busy=0", w, busy1, e[15:0]);
    end
  endtask

  task automatic test_zero_blank;
    logic [15:0] w;
    int multi;
    strobe1(8'd0);
    wait_drain(1'b0);
    collect(1'b0, w, multi);
    checks++;
    if (w !== 16'hFFF0 || multi != 0) begin
      errors++;
      $display("FAIL zero_units_only: got %h multi=%0d, required fff0 multi=0", w, multi);
    end
    blank = 1'b1;
    repeat (2) @(negedge clk);
    collect(1'b0, w, multi);
    checks++;
    if (w !== 16'hFFFF) begin
      errors++;
      $display("FAIL blank_dark: got %h, required ffff", w);
    end
    blank = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_during_conv;
    logic [15:0] w;
    int multi, busy_seen;
    strobe1(8'd99);
    strobe1(8'd98);
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL midconv_busy: got %b, required 1", busy1);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (busy1 !== 1'b0 || st1 !== 2'd0) begin
      errors++;
      $display("FAIL midconv_reset_idle: got busy=%b state=%0d, required 0 0", busy1, st1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy1) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL midconv_no_pending: got %0d busy cycles, required 0", busy_seen);
    end
    collect(1'b0, w, multi);
    checks++;
    if (w !== 16'hFFF0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL midconv_display_zero: got %h ovf=%b, required fff0 ovf=0", w, ovf1);
    end
  endtask

  task automatic test_random;
    logic [7:0] v;
    logic [16:0] e;
    logic [15:0] w;
    int multi;
    for (int n = 0; n < 6; n++) begin
      v = 8'($urandom_range(0, 255));
      e = exp_word(int'(v), (n % 2 == 0) ? 4 : 2);
      if (n % 2 == 0) strobe1(v); else strobe2(v);
      wait_drain(n % 2 == 1);
      collect(n % 2 == 1, w, multi);
      checks++;
      if (w !== e[15:0] || multi != 0) begin
        errors++;
        $display("FAIL random_%0d score=%0d: got %h multi=%0d, required %h", n, v, w, multi, e[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_zero_blank();
    test_reset_during_conv();
    test_random();
    checks++;
    if (exp_q.size() != 0 || exp_q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d/%0d entries, required 0/0", exp_q.size(), exp_q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
